hot_buffer_seq: RTL

HOT_BUFFER_SEQ -- requirements
Module: hot_buffer_seq

---
 rtl/hot_buffer_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hot_buffer_seq.sv
// Tile buffer sequencer: fills a row buffer once from a producer, then replays
// it for a configurable number of read passes, with a one-cycle registered read.
module hot_buffer_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] cfg_rows,
  input  logic [3:0] cfg_passes,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [5:0] rd_row,
  output logic [3:0] rd_pass,
  output logic       rd_last,
  output logic [5:0] buf_idx,
  output logic       buf_write_en,
  output logic       buf_read_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t     state_q, state_d;
  logic [5:0] rows_m1_q;
  logic [3:0] passes_m1_q;
  logic [5:0] fill_ptr_q;
  logic [5:0] rd_ptr_q;
  logic [3:0] pass_q;
  logic       start_acc;
  logic       row_end;
  logic       pass_end;
  logic       iss_last;

  logic       vld_p1;
  logic [5:0] row_p1;
  logic [3:0] pass_p1;
  logic       last_p1;

  // Row counts of 0 or above 64 select a full 64-row tile.
  function automatic logic [5:0] clamp_rows_m1(input logic [6:0] r);
    if (r == 7'd0 || r > 7'd64) return 6'd63;
    return 6'(r - 7'd1);
  endfunction

  function automatic logic [3:0] clamp_passes_m1(input logic [3:0] p);
    if (p == 4'd0) return 4'd0;
    return p - 4'd1;
  endfunction

  assign row_end  = (rd_ptr_q == rows_m1_q);
  assign pass_end = (pass_q == passes_m1_q);
  assign iss_last = buf_read_en && row_end && pass_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start_acc    = 1'b0;
    wr_ready     = 1'b0;
    buf_write_en = 1'b0;
    buf_read_en  = 1'b0;
    buf_idx      = 6'd0;
    busy         = (state_q != IDLE);
    done         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        wr_ready     = 1'b1;
        buf_write_en = wr_valid;
        if (wr_valid) begin
          buf_idx = fill_ptr_q;
          if (fill_ptr_q == rows_m1_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        buf_read_en = rd_ready;
        if (rd_ready) begin
          buf_idx = rd_ptr_q;
          if (row_end && pass_end) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: configuration latch and buffer pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_m1_q   <= 6'd0;
      passes_m1_q <= 4'd0;
      fill_ptr_q  <= 6'd0;
      rd_ptr_q    <= 6'd0;
      pass_q      <= 4'd0;
    end else begin
      if (start_acc) begin
        rows_m1_q   <= clamp_rows_m1(cfg_rows);
        passes_m1_q <= clamp_passes_m1(cfg_passes);
        fill_ptr_q  <= 6'd0;
        rd_ptr_q    <= 6'd0;
        pass_q      <= 4'd0;
      end
      if (buf_write_en) begin
        fill_ptr_q <= (fill_ptr_q == rows_m1_q) ? 6'd0 : fill_ptr_q + 6'd1;
      end
      if (buf_read_en) begin
        if (row_end) begin
          rd_ptr_q <= 6'd0;
          pass_q   <= pass_end ? 4'd0 : pass_q + 4'd1;
        end else begin
          rd_ptr_q <= rd_ptr_q + 6'd1;
        end
      end
    end
  end

  // Stage p1: tags aligned with the buffer's registered read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      row_p1  <= 6'd0;
      pass_p1 <= 4'd0;
    end else begin
      vld_p1  <= buf_read_en;
      last_p1 <= iss_last;
      if (buf_read_en) begin
        row_p1  <= rd_ptr_q;
        pass_p1 <= pass_q;
      end
    end
  end

  assign rd_valid = vld_p1;
  assign rd_row   = row_p1;
  assign rd_pass  = pass_p1;
  assign rd_last  = last_p1;

endmodule
